pwm_wave_sequencer: RTL and testbench
=====================================

Name: pwm_wave_sequencer

Overview:
- Controller that sequences a 64-step PWM datapath: a 6-bit PWM counter plus a 6-bit waveform index.
- Selects a waveform shape (off, square, sawtooth, triangle) and recomputes the duty cycle at every PWM frame boundary.
- Gates the output with an enable, using a graceful start/stop state machine.
- Accepts new configuration through a valid/ready handshake and applies it only at waveform-period boundaries, so output shapes never glitch.

Parameters:
- PRESC_W, 8, width of the tick prescaler reload value.
- SQ_LO, 16, first waveform index at which the square wave is high.
- SQ_HI, 47, last waveform index at which the square wave is high.

Ports:
- sysclk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run request; level-sensitive.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  no configuration pending; the offer is accepted when cfg_valid && cfg_ready.
- cfg_wave  in  2  0=off, 1=square, 2=sawtooth, 3=triangle.
- cfg_presc  in  PRESC_W  a tick occurs every cfg_presc+1 sysclk cycles.
- pulse  out  1  PWM output.
- duty  out  7  current frame duty, range 0..64.
- busy  out  1  state is not IDLE.
- period_done  out  1  one-cycle strobe at the end of each 64-frame waveform period.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; count=0, idx=0, presc_cnt=0, duty=0.
  - Active wave=off, active presc=0, pending flag=0.
  - Outputs: pulse=0, busy=0, period_done=0, cfg_ready=1.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN when enable=1. On entry: count=0, idx=0, presc_cnt=0, duty=f(wave,0).
  - RUN -> DRAIN when enable=0.
  - DRAIN -> RUN when enable=1, with no restart of count or idx.
  - DRAIN -> IDLE at the period end.
- Tick: when state != IDLE, tick=1 in a cycle where presc_cnt==active presc. On a tick presc_cnt reloads to 0; otherwise it increments.
- On each tick, count increments with 6-bit wrap. When count==63 on a tick:
  - idx increments with 6-bit wrap.
  - duty is loaded with f(wave, idx+1 mod 64). The new duty is visible on the cycle in which count becomes 0.
- Period end: a tick with count==63 && idx==63. period_done=1 for exactly that following cycle.
- Duty function f, 7-bit unsigned:
  - off: 0.
  - square: 64 if SQ_LO<=idx<=SQ_HI, else 0.
  - sawtooth: idx.
  - triangle: 2*idx for idx<32, else 2*(64-idx). This gives idx=32 -> 64 and idx=63 -> 2.
- pulse = (state != IDLE) && (count < duty), decoded from registers with no added latency.
  - duty=64 gives 100% high; duty=0 gives 0%.
- Configuration handshake:
  - On acceptance, cfg_wave and cfg_presc are captured into pending registers; pending=1 and cfg_ready=0 from the next cycle.
  - In IDLE, a pending config is applied on the next cycle.
  - In RUN or DRAIN, it is applied at the period end, in the same edge as the idx wrap, so idx 0 of the new period uses the new wave and the new presc.
  - Pending clears when the config is applied, and cfg_ready returns to 1 on the following cycle.
  - cfg_valid while cfg_ready=0 is ignored; the requester must hold the offer.
- Simultaneous events:
  - enable falling on the period-end cycle in RUN: go to IDLE directly.
  - Config application and period end in the same cycle: the new config wins for the next period.
  - IDLE with enable=1 and cfg_valid in the same cycle: start with the old config. The new config applies at the first period end.
- Reset mid-operation returns everything to reset values immediately; pulse goes low asynchronously.
- Width rules: count and idx are 6 bits. duty is 7 bits so that 64 is representable. The triangle arithmetic is computed in 7 bits with no overflow.

Test Plan:
- Reset and idle: assert rst_n=0 mid-RUN with pulse=1 -> pulse=0, busy=0 and cfg_ready=1 at once, without waiting for a clock edge; no activity while enable=0.
- Square, presc=0, enable held at 1:
  - idx 0..15 -> pulse=0 for 1024 cycles.
  - idx 16..47 -> pulse=1 continuously for 2048 cycles.
  - idx 48..63 -> pulse=0.
  - period_done fires every 4096 cycles.
- Sawtooth and triangle, presc=0:
  - Sawtooth frame idx=5 -> pulse high for exactly 5 of 64 cycles.
  - Triangle idx=10 -> 20 high cycles; idx=32 -> 64 high cycles (full); idx=63 -> 2 high cycles.
- Prescaler: presc=3, sawtooth -> each count step lasts 4 cycles; frame idx=1 -> 4 high cycles out of 256.
- Mid-run configuration: with wave=square and idx=20, offer sawtooth -> accepted in one cycle, cfg_ready=0, the square wave continues to idx=63, sawtooth starts at idx=0, and cfg_ready returns to 1 one cycle after application.
- Drain: drop enable at idx=30 -> busy stays 1 and the waveform completes; IDLE is reached after period_done. Reassert enable at idx=40 during DRAIN -> back to RUN with no idx reset.

Source files
------------

// File: rtl/pwm_wave_sequencer.sv
// PWM waveform sequencer: a 64-step PWM counter and a 64-frame waveform index.
// The frame duty is recomputed at each frame boundary from the selected shape.
// Run/stop is graceful through a drain state. New configuration is held as
// pending and takes effect only at a waveform-period boundary.
module pwm_wave_sequencer #(
  parameter int unsigned PRESC_W = 8,
  parameter int unsigned SQ_LO   = 16,
  parameter int unsigned SQ_HI   = 47
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_wave,
  input  logic [PRESC_W-1:0] cfg_presc,
  output logic               pulse,
  output logic [6:0]         duty,
  output logic               busy,
  output logic               period_done
);

  localparam logic [5:0] SqLo = 6'(SQ_LO);
  localparam logic [5:0] SqHi = 6'(SQ_HI);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e             state_q, state_d;
  logic [5:0]         count_q, count_d;
  logic [5:0]         idx_q, idx_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [6:0]         duty_q, duty_d;
  logic [1:0]         wave_q, wave_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               pend_q, pend_d;
  logic [1:0]         pend_wave_q, pend_wave_d;
  logic [PRESC_W-1:0] pend_presc_q, pend_presc_d;
  logic               period_done_q, period_done_d;

  logic               tick, frame_end, period_end, apply_cfg, accept;
  logic [1:0]         wave_nxt;

  // Duty for a waveform shape at a given index; 7 bits so that 64 fits.
  function automatic logic [6:0] wave_duty(input logic [1:0] wave, input logic [5:0] idx);
    logic [6:0] d;
    logic [6:0] tri_half;
    d        = 7'd0;
    tri_half = 7'd64 - {1'b0, idx};
    case (wave)
      2'd1:    d = ((idx >= SqLo) && (idx <= SqHi)) ? 7'd64 : 7'd0;
      2'd2:    d = {1'b0, idx};
      2'd3:    d = idx[5] ? {tri_half[5:0], 1'b0} : {idx, 1'b0};
      default: d = 7'd0;
    endcase
    return d;
  endfunction

  // Next-state: prescaler, counters, duty, config handshake and run/drain FSM.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    idx_d         = idx_q;
    presc_cnt_d   = presc_cnt_q;
    duty_d        = duty_q;
    wave_d        = wave_q;
    presc_d       = presc_q;
    pend_d        = pend_q;
    pend_wave_d   = pend_wave_q;
    pend_presc_d  = pend_presc_q;

    tick          = (state_q != StIdle) && (presc_cnt_q == presc_q);
    frame_end     = tick && (count_q == 6'd63);
    period_end    = frame_end && (idx_q == 6'd63);
    // Pending config lands immediately when idle, otherwise on the idx wrap.
    apply_cfg     = pend_q && ((state_q == StIdle) || period_end);
    accept        = cfg_valid && !pend_q;
    wave_nxt      = apply_cfg ? pend_wave_q : wave_q;
    period_done_d = period_end;

    if (apply_cfg) begin
      wave_d  = pend_wave_q;
      presc_d = pend_presc_q;
      pend_d  = 1'b0;
    end
    if (accept) begin
      pend_d       = 1'b1;
      pend_wave_d  = cfg_wave;
      pend_presc_d = cfg_presc;
    end

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d     = StRun;
          count_d     = 6'd0;
          idx_d       = 6'd0;
          presc_cnt_d = '0;
          duty_d      = wave_duty(wave_nxt, 6'd0);
        end
      end
      StRun, StDrain: begin
        presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
        if (tick) count_d = count_q + 6'd1;
        if (frame_end) begin
          idx_d  = idx_q + 6'd1;
          duty_d = wave_duty(wave_nxt, idx_q + 6'd1);
        end
        if (state_q == StRun) begin
          // Stopping exactly on the period end skips the drain period.
          if (!enable) state_d = period_end ? StIdle : StDrain;
        end else begin
          if (enable)          state_d = StRun;
          else if (period_end) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      count_q       <= 6'd0;
      idx_q         <= 6'd0;
      presc_cnt_q   <= '0;
      duty_q        <= 7'd0;
      wave_q        <= 2'd0;
      presc_q       <= '0;
      pend_q        <= 1'b0;
      pend_wave_q   <= 2'd0;
      pend_presc_q  <= '0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      presc_cnt_q   <= presc_cnt_d;
      duty_q        <= duty_d;
      wave_q        <= wave_d;
      presc_q       <= presc_d;
      pend_q        <= pend_d;
      pend_wave_q   <= pend_wave_d;
      pend_presc_q  <= pend_presc_d;
      period_done_q <= period_done_d;
    end
  end

  // Outputs decoded straight from registers; pulse falls with the async reset.
  always_comb begin
    busy        = (state_q != StIdle);
    pulse       = busy && ({1'b0, count_q} < duty_q);
    duty        = duty_q;
    cfg_ready   = !pend_q;
    period_done = period_done_q;
  end

endmodule

// File: tb/tb_pwm_wave_sequencer.sv
// Self-checking bench for pwm_wave_sequencer: table of per-frame duty vectors
// plus hand-written multi-cycle sequences (period strobe, mid-run config,
// drain, stop on period end, asynchronous reset).
module tb_pwm_wave_sequencer;

  logic       sysclk;
  logic       rst_n;
  logic       enable;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_wave;
  logic [7:0] cfg_presc;
  logic       pulse;
  logic [6:0] duty;
  logic       busy;
  logic       period_done;

  pwm_wave_sequencer #(
    .PRESC_W(8),
    .SQ_LO  (16),
    .SQ_HI  (47)
  ) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_wave   (cfg_wave),
    .cfg_presc  (cfg_presc),
    .pulse      (pulse),
    .duty       (duty),
    .busy       (busy),
    .period_done(period_done)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [1:0] wave;
    logic [7:0] presc;
    int         idx;
    int         exp_duty;
    int         exp_hi;
  } vec_t;

  vec_t vecs[14];
  int   exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Advance to the sample point (negedge) of cycle n counted from run start.
  task automatic tick_to(input int n);
    while (cyc < n) begin
      @(negedge sysclk);
      cyc++;
    end
  endtask

  task automatic count_high(input int from, input int len, output int hi);
    tick_to(from);
    hi = 0;
    for (int i = 0; i < len; i++) begin
      if (pulse) hi++;
      @(negedge sysclk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    enable    = 1'b0;
    cfg_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);
  endtask

  // Offer a config while idle: accepted on one edge, applied on the next.
  task automatic configure(input logic [1:0] w, input logic [7:0] p);
    cfg_valid = 1'b1;
    cfg_wave  = w;
    cfg_presc = p;
    @(negedge sysclk);
    cfg_valid = 1'b0;
    @(negedge sysclk);
  endtask

  // Cycle 0 is the first cycle in RUN.
  task automatic start_run();
    enable = 1'b1;
    @(negedge sysclk);
    cyc = 0;
  endtask

  int hi, pd, bz, fl;

  initial begin
    rst_n     = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_wave  = 2'd0;
    cfg_presc = 8'd0;

    //             wave   presc idx duty high
    vecs[0]  = '{2'd1, 8'd0, 0,  0,  0};
    vecs[1]  = '{2'd1, 8'd0, 15, 0,  0};
    vecs[2]  = '{2'd1, 8'd0, 16, 64, 64};
    vecs[3]  = '{2'd1, 8'd0, 47, 64, 64};
    vecs[4]  = '{2'd1, 8'd0, 48, 0,  0};
    vecs[5]  = '{2'd2, 8'd0, 5,  5,  5};
    vecs[6]  = '{2'd3, 8'd0, 10, 20, 20};
    vecs[7]  = '{2'd3, 8'd0, 32, 64, 64};
    vecs[8]  = '{2'd3, 8'd0, 63, 2,  2};
    vecs[9]  = '{2'd2, 8'd3, 1,  1,  4};
    vecs[10] = '{2'd0, 8'd0, 20, 0,  0};
    vecs[11] = '{2'd3, 8'd1, 31, 62, 124};
    vecs[12] = '{2'd2, 8'd0, 63, 63, 63};
    vecs[13] = '{2'd3, 8'd0, 33, 62, 62};

    // Reset values, observed before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_pulse", int'(pulse), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_period_done", int'(period_done), 0);
    check("rst_duty", int'(duty), 0);
    @(negedge sysclk);
    rst_n = 1'b1;
    bz = 0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (busy) bz++;
      if (pulse) hi++;
    end
    check("idle_busy", bz, 0);
    check("idle_pulse", hi, 0);

    // Table: duty at a frame start and high cycles within that frame.
    for (int i = 0; i < 14; i++) begin
      int f;
      do_reset();
      configure(vecs[i].wave, vecs[i].presc);
      exp_q.push_back(vecs[i].exp_hi);
      start_run();
      f = 64 * (int'(vecs[i].presc) + 1);
      tick_to(vecs[i].idx * f);
      check($sformatf("vec%0d_duty", i), int'(duty), vecs[i].exp_duty);
      count_high(vecs[i].idx * f, f, hi);
      check($sformatf("vec%0d_high", i), hi, exp_q.pop_front());
      enable = 1'b0;
    end

    // Square over two periods: segment highs and period_done spacing.
    do_reset();
    configure(2'd1, 8'd0);
    start_run();
    begin
      int h0, h1, h2;
      h0 = 0; h1 = 0; h2 = 0; pd = 0;
      for (int n = 0; n < 4096; n++) begin
        tick_to(n);
        if (pulse && n < 1024) h0++;
        if (pulse && n >= 1024 && n < 3072) h1++;
        if (pulse && n >= 3072) h2++;
        if (period_done) pd++;
      end
      check("sq_low_head", h0, 0);
      check("sq_high_mid", h1, 2048);
      check("sq_low_tail", h2, 0);
      check("sq_pd_early", pd, 0);
    end
    tick_to(4096);
    check("sq_pd_4096", int'(period_done), 1);
    pd = 0;
    for (int n = 4097; n < 8192; n++) begin
      tick_to(n);
      if (period_done) pd++;
    end
    check("sq_pd_gap", pd, 0);
    tick_to(8192);
    check("sq_pd_8192", int'(period_done), 1);
    enable = 1'b0;

    // Mid-run config: square until the period end, sawtooth afterwards.
    do_reset();
    configure(2'd1, 8'd0);
    start_run();
    tick_to(1280);
    check("cfg_sq_duty_idx20", int'(duty), 64);
    cfg_valid = 1'b1;
    cfg_wave  = 2'd2;
    cfg_presc = 8'd0;
    tick_to(1281);
    cfg_valid = 1'b0;
    check("cfg_accepted", int'(cfg_ready), 0);
    count_high(1344, 1728, hi);
    check("cfg_sq_continues", hi, 1728);
    count_high(3072, 1023, hi);
    check("cfg_sq_tail_low", hi, 0);
    tick_to(4095);
    check("cfg_ready_before", int'(cfg_ready), 0);
    tick_to(4096);
    check("cfg_ready_after", int'(cfg_ready), 1);
    check("cfg_pd", int'(period_done), 1);
    count_high(4160, 64, hi);
    check("cfg_saw_idx1", hi, 1);
    tick_to(4416);
    check("cfg_saw_duty_idx5", int'(duty), 5);
    enable = 1'b0;

    // Drain: drop at idx 30, resume at idx 40, drop at idx 50, finish period.
    do_reset();
    configure(2'd1, 8'd0);
    start_run();
    bz = 0;
    hi = 0;
    for (int n = 1920; n < 4096; n++) begin
      tick_to(n);
      if (!busy) bz++;
      if (pulse && n >= 2560 && n < 3072) hi++;
      if (n == 1920) enable = 1'b0;
      if (n == 2560) enable = 1'b1;
      if (n == 3200) enable = 1'b0;
    end
    check("drain_busy", bz, 0);
    check("drain_no_idx_reset", hi, 512);
    tick_to(4096);
    check("drain_idle", int'(busy), 0);
    check("drain_pd", int'(period_done), 1);

    // Enable falls exactly on the period-end cycle: straight to IDLE.
    do_reset();
    configure(2'd2, 8'd0);
    start_run();
    tick_to(4095);
    enable = 1'b0;
    tick_to(4096);
    check("stop_on_end_idle", int'(busy), 0);
    check("stop_on_end_pd", int'(period_done), 1);

    // Asynchronous reset with pulse high and a config pending.
    do_reset();
    configure(2'd1, 8'd0);
    start_run();
    tick_to(1300);
    check("arst_pre_pulse", int'(pulse), 1);
    cfg_valid = 1'b1;
    cfg_wave  = 2'd3;
    tick_to(1301);
    cfg_valid = 1'b0;
    check("arst_pre_ready", int'(cfg_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pulse", int'(pulse), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_ready", int'(cfg_ready), 1);
    check("arst_duty", int'(duty), 0);
    enable = 1'b0;
    @(negedge sysclk);
    rst_n = 1'b1;
    fl = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (busy || pulse) fl++;
    end
    check("arst_idle_quiet", fl, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
